// File: rtl/clr_gen_pkg.sv
// Shared definitions for the clear-pulse generator: FSM state encoding and
// the counter-width helper used by the generator and its debouncer.
package clr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Bits needed to hold the largest of three counts.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clr_debounce.sv
// Two-flop synchroniser and debouncer for the raw external clear input;
// emits a one-cycle pulse when the debounced level rises.
module clr_debounce
    import clr_gen_pkg::*;
#(
    parameter int unsigned DEB_CYC = 8
) (
    input  logic C,
    input  logic R,
    input  logic EXT,
    output logic deb_rise
);

    localparam int unsigned    DW   = cnt_width(DEB_CYC, 0, 0);
    localparam logic [DW-1:0]  LAST = DW'(DEB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_rise;
    logic [DW-1:0] r_cnt;

    // Count consecutive synchronised samples that disagree with the accepted
    // level; any sample matching it again restarts the count.
    always_ff @(posedge C) begin
        if (R) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= EXT;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt  <= '0;
                r_deb  <= r_sync2;
                r_rise <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign deb_rise = r_rise;

endmodule

// File: rtl/clr_pulse_gen.sv
// Clear-pulse generator: stretches each clear request into a registered CLR
// pulse, enforces a hold-off window, then pulses DONE once per sequence.
module clr_pulse_gen
    import clr_gen_pkg::*;
#(
    parameter int unsigned STRETCH = 4,
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned DEB_CYC = 8
) (
    input  logic C,
    input  logic R,
    input  logic REQ,
    input  logic EXT,
    output logic CLR,
    output logic BUSY,
    output logic DONE
);

    localparam int unsigned   CW       = cnt_width(STRETCH, HOLDOFF, DEB_CYC);
    localparam logic [CW-1:0] STR_LOAD = CW'(STRETCH - 1);
    localparam logic [CW-1:0] HLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;
    localparam bit            HAS_HOLD = (HOLDOFF != 0);

    logic          w_deb_rise;
    logic          w_trig;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_str_cnt;
    logic [CW-1:0] w_str_cnt_nxt;
    logic [CW-1:0] r_hld_cnt;
    logic [CW-1:0] w_hld_cnt_nxt;
    logic          w_done_nxt;
    logic          r_clr;
    logic          r_busy;
    logic          r_done;

    clr_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .C        (C),
        .R        (R),
        .EXT      (EXT),
        .deb_rise (w_deb_rise)
    );

    assign w_trig = REQ | w_deb_rise;

    always_comb begin
        w_state_nxt   = r_state;
        w_str_cnt_nxt = r_str_cnt;
        w_hld_cnt_nxt = r_hld_cnt;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nxt   = ASSERT;
                    w_str_cnt_nxt = STR_LOAD;
                end
            end
            ASSERT: begin
                if (w_trig) begin
                    w_str_cnt_nxt = STR_LOAD;
                end else if (r_str_cnt == '0) begin
                    if (HAS_HOLD) begin
                        w_state_nxt   = HOLD;
                        w_hld_cnt_nxt = HLD_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_str_cnt_nxt = r_str_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (w_trig) begin
                    w_state_nxt   = ASSERT;
                    w_str_cnt_nxt = STR_LOAD;
                end else if (r_hld_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_hld_cnt_nxt = r_hld_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so CLR is a pure flop output.
    always_ff @(posedge C) begin
        if (R) begin
            r_state   <= ASSERT;
            r_str_cnt <= STR_LOAD;
            r_hld_cnt <= '0;
            r_clr     <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_str_cnt <= w_str_cnt_nxt;
            r_hld_cnt <= w_hld_cnt_nxt;
            r_clr     <= (w_state_nxt == ASSERT);
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign CLR  = r_clr;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_clr_pulse_gen.sv
// Bench for clr_pulse_gen: a default build and a STRETCH=1/HOLDOFF=0 build share
// stimulus and are compared every cycle against a behavioural model.
module tb_clr_pulse_gen;

    localparam int unsigned NI = 2;

    logic       C;
    logic       R;
    logic       REQ;
    logic       EXT;
    logic [1:0] w_clr;
    logic [1:0] w_busy;
    logic [1:0] w_done;

    int checks   = 0;
    int failures = 0;

    clr_pulse_gen #(
        .STRETCH (4),
        .HOLDOFF (2),
        .DEB_CYC (8)
    ) dut (
        .C    (C),
        .R    (R),
        .REQ  (REQ),
        .EXT  (EXT),
        .CLR  (w_clr[0]),
        .BUSY (w_busy[0]),
        .DONE (w_done[0])
    );

    clr_pulse_gen #(
        .STRETCH (1),
        .HOLDOFF (0),
        .DEB_CYC (3)
    ) dut1 (
        .C    (C),
        .R    (R),
        .REQ  (REQ),
        .EXT  (EXT),
        .CLR  (w_clr[1]),
        .BUSY (w_busy[1]),
        .DONE (w_done[1])
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    // Model: remaining CLR cycles / hold cycles per build, plus run-length view
    // of the synchronised EXT samples.
    int unsigned m_S [NI] = '{4, 1};
    int unsigned m_H [NI] = '{2, 0};
    int unsigned m_D [NI] = '{8, 3};
    int unsigned m_clr_left  [NI];
    int unsigned m_hold_left [NI];
    bit          m_done [NI];
    bit          m_deb  [NI];
    bit          m_rise [NI];
    bit          m_s1, m_s2, m_last;
    int unsigned m_run;

    int cnt_clr0;
    int cnt_done0;

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, act, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        checks++;
        assert (act == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic req, input logic ext);
        bit trig;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_last = 1'b0; m_run = 0;
            for (int unsigned i = 0; i < NI; i++) begin
                m_deb[i] = 1'b0; m_rise[i] = 1'b0; m_done[i] = 1'b0;
                m_clr_left[i] = m_S[i]; m_hold_left[i] = 0;
            end
        end else begin
            if (m_s2 == m_last) m_run++;
            else begin m_last = m_s2; m_run = 1; end
            for (int unsigned i = 0; i < NI; i++) begin
                trig = req | m_rise[i];
                m_done[i] = 1'b0;
                m_rise[i] = 1'b0;
                if (m_run >= m_D[i] && m_last != m_deb[i]) begin
                    m_deb[i]  = m_last;
                    m_rise[i] = m_last;
                end
                if (trig) begin
                    m_clr_left[i]  = m_S[i];
                    m_hold_left[i] = 0;
                end else if (m_clr_left[i] > 0) begin
                    m_clr_left[i]--;
                    if (m_clr_left[i] == 0) begin
                        if (m_H[i] > 0) m_hold_left[i] = m_H[i];
                        else            m_done[i] = 1'b1;
                    end
                end else if (m_hold_left[i] > 0) begin
                    m_hold_left[i]--;
                    if (m_hold_left[i] == 0) m_done[i] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = ext;
        end
    endtask

    task automatic tick(input logic r, input logic req, input logic ext);
        R = r; REQ = req; EXT = ext;
        @(posedge C);
        model_step(r, req, ext);
        @(negedge C);
        for (int unsigned i = 0; i < NI; i++) begin
            chk($sformatf("clr%0d", i),  w_clr[i],  logic'(m_clr_left[i] > 0));
            chk($sformatf("busy%0d", i), w_busy[i], logic'(m_clr_left[i] > 0 || m_hold_left[i] > 0));
            chk($sformatf("done%0d", i), w_done[i], logic'(m_done[i]));
        end
        if (w_clr[0] === 1'b1)  cnt_clr0++;
        if (w_done[0] === 1'b1) cnt_done0++;
    endtask

    initial begin
        int n;
        R = 1'b1; REQ = 1'b0; EXT = 1'b0;
        cnt_clr0 = 0; cnt_done0 = 0;

        // Power-on clear
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        chk("rst_clr", w_clr[0], 1'b1);
        chk("rst_busy", w_busy[0], 1'b1);
        chk("rst_done", w_done[0], 1'b0);
        cnt_done0 = 0;
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        chk_int("rst_done_count", cnt_done0, 1);
        chk("rst_idle", w_busy[0], 1'b0);

        // Single REQ pulse; STRETCH=1 build gives a one-cycle CLR then DONE
        cnt_clr0 = 0; cnt_done0 = 0;
        tick(1'b0, 1'b1, 1'b0);
        chk("s1_clr_on", w_clr[1], 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("s1_clr_off", w_clr[1], 1'b0);
        chk("s1_done", w_done[1], 1'b1);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        chk_int("pulse_clr_len", cnt_clr0, 4);
        chk_int("pulse_done_count", cnt_done0, 1);

        // Retrigger two edges later extends CLR to 6 cycles
        cnt_clr0 = 0; cnt_done0 = 0;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        chk_int("retrig_clr_len", cnt_clr0, 6);
        chk_int("retrig_done_count", cnt_done0, 1);

        // REQ landing in HOLD restarts the pulse without an intervening DONE
        cnt_clr0 = 0; cnt_done0 = 0;
        tick(1'b0, 1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        chk("in_hold", w_clr[0], 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("hold_retrig", w_clr[0], 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        chk_int("hold_clr_len", cnt_clr0, 8);
        chk_int("hold_done_count", cnt_done0, 1);

        // Reset during the STRETCH=1 pulse restarts its full count
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("mid_rst_clr", w_clr[1], 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("mid_rst_clr_off", w_clr[1], 1'b0);
        chk("mid_rst_done", w_done[1], 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b0);

        // Bouncing EXT, then a stable high level
        cnt_clr0 = 0; cnt_done0 = 0;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'((i / 3) % 2));
        chk_int("bounce_no_clr", cnt_clr0, 0);
        n = 0;
        do begin
            tick(1'b0, 1'b0, 1'b1);
            n++;
        end while (w_clr[0] !== 1'b1 && n < 40);
        chk_int("ext_latency", n, 11);
        repeat (20) tick(1'b0, 1'b0, 1'b1);
        chk_int("ext_clr_len", cnt_clr0, 4);
        chk_int("ext_done_count", cnt_done0, 1);

        // Random traffic against the model
        begin
            logic ext_r;
            ext_r = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(5) == 0) ext_r = ~ext_r;
                tick(logic'($urandom_range(59) == 0),
                     logic'($urandom_range(9) == 0),
                     ext_r);
            end
        end
        repeat (20) tick(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
